// File: rtl/regaccess_pkg.sv
// Shared definitions for the register-access SPI link: frame geometry and the
// transaction state encoding used by both ends of the link.
package regaccess_pkg;

    localparam int FRAME_BITS     = 16;
    localparam int WRITE_FLAG_BIT = 7;
    localparam int REGNUM_W       = 7;
    localparam int DATA_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    // Byte 0 is {write, regnum}; byte 1 carries wdata on writes and zero on reads.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                write,
        input logic [REGNUM_W-1:0] regnum,
        input logic [DATA_W-1:0]   wdata
    );
        logic [DATA_W-1:0] hdr;
        hdr                 = '0;
        hdr[REGNUM_W-1:0]   = regnum;
        hdr[WRITE_FLAG_BIT] = write;
        return {hdr, (write ? wdata : {DATA_W{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled and flags the
// terminal count with a one-cycle tick.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERM) ? 8'd0 : count + 8'd1;
        end
    end

    assign tick = enable && !clear && (count == TERM);

endmodule

// File: rtl/regaccess_master.sv
// SPI mode-0 initiator that serialises one {write, regnum, wdata} request into
// a 16-bit frame and returns read data in parallel.
module regaccess_master
    import regaccess_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                write,
    input  logic [REGNUM_W-1:0] regnum,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                ss,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso
);

    state_t                  state, state_next;
    logic                    tick;
    logic                    last_fall;
    logic [FRAME_BITS-1:0]   tx_sr;
    logic [FRAME_BITS-1:0]   rx_sr;
    logic [3:0]              bit_cnt;
    logic                    write_q;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .tick   (tick)
    );

    // The 16th falling edge is the tick that lowers sclk with all bits sent.
    assign last_fall = tick && sclk && (bit_cnt == 4'd15);

    // NOTE: state and all datapath registers use non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = SETUP;
            SETUP:   if (tick)      state_next = SHIFT;
            SHIFT:   if (last_fall) state_next = HOLD;
            HOLD:    if (tick)      state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss      <= 1'b1;
            sclk    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            write_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= build_frame(write, regnum, wdata);
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        write_q <= write;
                        ss      <= 1'b0;
                        busy    <= 1'b1;
                    end else if (done) begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[FRAME_BITS-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt != 4'd15) begin
                                tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    ss    <= 1'b1;
                    done  <= 1'b1;
                    tx_sr <= '0;
                    if (!write_q) begin
                        rdata <= rx_sr[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign mosi = tx_sr[FRAME_BITS-1];

endmodule

// File: tb/tb_regaccess_master.sv
// Bench for regaccess_master: a CLK_DIV=4 and a CLK_DIV=1 instance, each wired
// to a behavioural register-file slave, with completions checked from a queue.
module tb_regaccess_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s  [2];
    logic       write_s  [2];
    logic [6:0] regnum_s [2];
    logic [7:0] wdata_s  [2];
    logic       busy_s   [2];
    logic       done_s   [2];
    logic [7:0] rdata_s  [2];
    logic       ss_s     [2];
    logic       sclk_s   [2];
    logic       mosi_s   [2];
    logic       miso_s   [2];

    always #5 clk = ~clk;

    regaccess_master #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .write(write_s[0]),
        .regnum(regnum_s[0]), .wdata(wdata_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .rdata(rdata_s[0]), .ss(ss_s[0]), .sclk(sclk_s[0]),
        .mosi(mosi_s[0]), .miso(miso_s[0])
    );

    regaccess_master #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .write(write_s[1]),
        .regnum(regnum_s[1]), .wdata(wdata_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .rdata(rdata_s[1]), .ss(ss_s[1]), .sclk(sclk_s[1]),
        .mosi(mosi_s[1]), .miso(miso_s[1])
    );

    typedef struct {
        int          inst;
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          e_cyc;
    } exp_t;

    typedef struct {
        logic        w;
        logic [6:0]  r;
        logic [7:0]  d;
        logic [15:0] frame;
        logic [7:0]  rd;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          done_cnt[2];
    int          rise_cnt[2];
    logic [15:0] shift_in[2];
    logic [7:0]  hdr[2];
    logic        sclk_prev[2];
    logic        ss_prev[2];
    logic [7:0]  mem[2][128];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: captures mosi on sclk rises, serves reads in byte 1, and
    // commits writes on the 16th rise. Completion monitor follows.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_s[i]) begin
                rise_cnt[i] = 0;
                miso_s[i]   = 1'b0;
            end else begin
                if (ss_prev[i]) begin
                    shift_in[i] = '0;
                    hdr[i]      = '0;
                end
                if (sclk_s[i] && !sclk_prev[i]) begin
                    shift_in[i] = {shift_in[i][14:0], mosi_s[i]};
                    rise_cnt[i]++;
                    if (rise_cnt[i] == 8) hdr[i] = shift_in[i][7:0];
                    if (rise_cnt[i] == 16 && hdr[i][7]) mem[i][hdr[i][6:0]] = shift_in[i][7:0];
                end
                if (rise_cnt[i] >= 8 && rise_cnt[i] < 16 && !hdr[i][7])
                    miso_s[i] = mem[i][hdr[i][6:0]][15 - rise_cnt[i]];
                else
                    miso_s[i] = 1'b0;
            end
            sclk_prev[i] = sclk_s[i];
            ss_prev[i]   = ss_s[i];
        end
        for (int i = 0; i < 2; i++) begin
            if (done_s[i]) begin
                exp_t e;
                done_cnt[i]++;
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_inst", i, e.inst);
                    check("rdata", rdata_s[i], e.rdata);
                    check("mosi_frame", shift_in[i], e.frame);
                    check("latency", cyc - e.e_cyc, (i == 0) ? 137 : 35);
                end
            end
        end
    end

    task automatic launch(input int i, input logic w, input logic [6:0] r, input logic [7:0] d,
                          input logic [15:0] fr, input logic [7:0] rd, input bit track);
        exp_t e;
        @(negedge clk);
        start_s[i] = 1'b1; write_s[i] = w; regnum_s[i] = r; wdata_s[i] = d;
        if (track) begin
            e.inst = i; e.frame = fr; e.rdata = rd; e.e_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start_s[i] = 1'b0; write_s[i] = 1'b0; regnum_s[i] = '0; wdata_s[i] = '0;
        check("busy_after_accept", busy_s[i], 1'b1);
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!done_s[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_s[i], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 128; a++) mem[i][a] = 8'h00;
            mem[i][0] = 8'h10; mem[i][1] = 8'h3C; mem[i][2] = 8'hA5; mem[i][3] = 8'h5A;
            start_s[i] = 1'b0; write_s[i] = 1'b0; regnum_s[i] = '0; wdata_s[i] = '0;
            miso_s[i] = 1'b0; done_cnt[i] = 0; rise_cnt[i] = 0;
            shift_in[i] = '0; hdr[i] = '0; sclk_prev[i] = 1'b0; ss_prev[i] = 1'b1;
        end
        vecs[0] = '{w: 1'b1, r: 7'h05, d: 8'h80, frame: 16'h8580, rd: 8'h00};
        vecs[1] = '{w: 1'b0, r: 7'h00, d: 8'hFF, frame: 16'h0000, rd: 8'h10};
        vecs[2] = '{w: 1'b1, r: 7'h7F, d: 8'h5A, frame: 16'hFF5A, rd: 8'h10};
        vecs[3] = '{w: 1'b0, r: 7'h7F, d: 8'h00, frame: 16'h7F00, rd: 8'h5A};
        vecs[4] = '{w: 1'b0, r: 7'h05, d: 8'h33, frame: 16'h0500, rd: 8'h80};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ss", ss_s[i], 1'b1);
            check("rst_sclk", sclk_s[i], 1'b0);
            check("rst_mosi", mosi_s[i], 1'b0);
            check("rst_busy", busy_s[i], 1'b0);
            check("rst_done", done_s[i], 1'b0);
            check("rst_rdata", rdata_s[i], 8'h00);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            launch(0, vecs[k].w, vecs[k].r, vecs[k].d, vecs[k].frame, vecs[k].rd, 1'b1);
            wait_done(0, 300);
            @(negedge clk);
            check("busy_drop", busy_s[0], 1'b0);
            if (vecs[k].w) check("slave_reg", mem[0][vecs[k].r], vecs[k].d);
        end

        // start while busy must be neither queued nor acknowledged
        base = done_cnt[0];
        launch(0, 1'b0, 7'h01, 8'h00, 16'h0100, 8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        start_s[0] = 1'b1; write_s[0] = 1'b1; regnum_s[0] = 7'h22; wdata_s[0] = 8'hFF;
        @(negedge clk);
        start_s[0] = 1'b0; write_s[0] = 1'b0; regnum_s[0] = '0; wdata_s[0] = '0;
        wait_done(0, 300);
        repeat (200) @(negedge clk);
        check("single_done", done_cnt[0] - base, 1);
        check("ignored_write", mem[0][7'h22], 8'h00);

        // reset after the 7th sclk rise aborts the frame silently
        base = done_cnt[0];
        launch(0, 1'b1, 7'h10, 8'hEE, 16'h90EE, 8'h00, 1'b0);
        n = 0;
        while (rise_cnt[0] != 7 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reached_rise7", rise_cnt[0], 7);
        rst = 1'b1;
        #1;
        check("abort_ss", ss_s[0], 1'b1);
        check("abort_sclk", sclk_s[0], 1'b0);
        check("abort_mosi", mosi_s[0], 1'b0);
        check("abort_busy", busy_s[0], 1'b0);
        check("abort_rdata", rdata_s[0], 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_no_done", done_cnt[0] - base, 0);
        check("abort_no_write", mem[0][7'h10], 8'h00);
        launch(0, 1'b0, 7'h01, 8'h00, 16'h0100, 8'h3C, 1'b1);
        wait_done(0, 300);

        // CLK_DIV=1 back-to-back reads, second start held from the done cycle
        launch(1, 1'b0, 7'h02, 8'h00, 16'h0200, 8'hA5, 1'b1);
        wait_done(1, 100);
        begin
            exp_t e;
            check("gap_ss_high", ss_s[1], 1'b1);
            start_s[1] = 1'b1; write_s[1] = 1'b0; regnum_s[1] = 7'h03;
            e.inst = 1; e.frame = 16'h0300; e.rdata = 8'h5A; e.e_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start_s[1] = 1'b0; regnum_s[1] = '0;
        check("gap_one_cycle", ss_s[1], 1'b0);
        check("b2b_busy", busy_s[1], 1'b1);
        wait_done(1, 100);
        @(negedge clk);
        check("b2b_busy_drop", busy_s[1], 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
